// File: rtl/elastic_delay_pipe.sv
// rtl/elastic_delay_pipe.sv - multi-lane fixed-depth delay pipe with valid/ready, bubble collapse and flush
// Stage 0 is the input side; stage STAGES-1 drives the output.
module elastic_delay_pipe #(
  parameter int DATA_SIZE       = 32,
  parameter int LANES           = 1,
  parameter int STAGES          = 2,
  parameter bit BUBBLE_COLLAPSE = 1'b1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_SIZE-1:0]       in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*DATA_SIZE-1:0]       out_data,
  output logic [$clog2(STAGES+1)-1:0]      occupancy
);

  localparam int W     = LANES * DATA_SIZE;
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q;
  logic [W-1:0]      data_q [STAGES];

  logic [STAGES:0]   rdy;
  logic [STAGES-1:0] src_valid;
  logic [W-1:0]      src_data [STAGES];
  logic              in_fire;
  logic              out_fire;

  // Ready ripples back from the output; a running term avoids a self-referencing vector.
  always_comb begin
    logic r;
    r = out_ready;
    rdy = '0;
    rdy[STAGES] = r;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (BUBBLE_COLLAPSE)
        r = r | ~valid_q[i];
      rdy[i] = r;
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    src_valid[0] = in_fire;
    src_data[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  // Data only loads behind a valid source so bubbles do not toggle the datapath.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q   <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++)
        data_q[i] <= '0;
    end else if (flush) begin
      valid_q   <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          valid_q[i] <= src_valid[i];
          if (src_valid[i])
            data_q[i] <= src_data[i];
        end
      end
      if (in_fire && !out_fire)
        occupancy <= occupancy + OCC_W'(1);
      else if (!in_fire && out_fire)
        occupancy <= occupancy - OCC_W'(1);
    end
  end

  occupancy_matches_valid : assert property (@(posedge clk) disable iff (!rstn)
    occupancy == OCC_W'($countones(valid_q)));

endmodule

// File: tb/tb_elastic_delay_pipe.sv
// tb/tb_elastic_delay_pipe.sv - scoreboard bench over four pipe configurations sharing one stimulus
// Instances: 0 S=2 collapse, 1 S=3x4 lanes collapse, 2 S=3x4 lanes lockstep, 3 S=1 collapse.
module tb_elastic_delay_pipe;

  logic clk = 1'b0;
  logic rstn, flush, in_valid, out_ready, mon_en;
  logic [31:0] in_data;
  logic [3:0] ir, ov;
  logic [3:0][31:0] od;
  logic [1:0] occ0, occ1, occ2;
  logic occ3;
  int errors = 0;
  int checks = 0;

  typedef struct { int k; logic [31:0] d; int age; int adv; } item_t;
  item_t sb[$];

  always #5 clk = ~clk;

  elastic_delay_pipe #(.DATA_SIZE(32), .LANES(1), .STAGES(2), .BUBBLE_COLLAPSE(1'b1)) u0 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .occupancy(occ0));
  elastic_delay_pipe #(.DATA_SIZE(8), .LANES(4), .STAGES(3), .BUBBLE_COLLAPSE(1'b1)) u1 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .occupancy(occ1));
  elastic_delay_pipe #(.DATA_SIZE(8), .LANES(4), .STAGES(3), .BUBBLE_COLLAPSE(1'b0)) u2 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .occupancy(occ2));
  elastic_delay_pipe #(.DATA_SIZE(32), .LANES(1), .STAGES(1), .BUBBLE_COLLAPSE(1'b1)) u3 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .occupancy(occ3));

  function automatic int stg(input int k);
    case (k)
      0: return 2;
      3: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit col(input int k);
    return k != 2;
  endfunction

  function automatic logic [31:0] occ_of(input int k);
    case (k)
      0: return 32'(occ0);
      1: return 32'(occ1);
      2: return 32'(occ2);
      default: return 32'(occ3);
    endcase
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Model: per item, age = cycles in flight, adv = cycles in flight with out_ready high.
  // Every out_ready cycle moves every item one stage, and no item moves more than one stage per cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] fire;
      fire = '0;
      for (int k = 0; k < 4; k++) begin
        int cnt;
        int fi;
        logic eir;
        cnt = 0;
        fi = -1;
        foreach (sb[j]) begin
          if (sb[j].k == k) begin
            if (fi < 0) fi = j;
            cnt++;
          end
        end
        eir = !flush && (out_ready || (col(k) && cnt < stg(k)));
        chk("in_ready", k, 32'(ir[k]), 32'(eir));
        chk("occupancy", k, occ_of(k), 32'(cnt));
        if (fi >= 0 && sb[fi].adv >= stg(k))
          chk("out_valid", k, 32'(ov[k]), 32'd1);
        else if (fi < 0 || sb[fi].age < stg(k) || !col(k))
          chk("out_valid", k, 32'(ov[k]), 32'd0);
        if (ov[k] === 1'b1 && fi >= 0) begin
          chk("out_data", k, od[k], sb[fi].d);
          if (out_ready) sb.delete(fi);
        end
        fire[k] = in_valid && eir;
      end
      if (!rstn || flush) begin
        sb.delete();
      end else begin
        foreach (sb[j]) begin
          sb[j].age++;
          if (out_ready && sb[j].adv < stg(sb[j].k)) sb[j].adv++;
        end
        for (int k = 0; k < 4; k++)
          if (fire[k]) sb.push_back('{k: k, d: in_data, age: 1, adv: 1});
      end
    end
  end

  task automatic set(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    set(v, d, r, f);
    tick();
  endtask

  task automatic chk_empty(input string name);
    for (int k = 0; k < 4; k++) begin
      chk({name, "_valid"}, k, 32'(ov[k]), 32'd0);
      chk({name, "_occ"}, k, occ_of(k), 32'd0);
    end
  endtask

  initial begin
    rstn = 1'b0; mon_en = 1'b0;
    set(0, 0, 1, 0);
    tick(); tick();
    chk_empty("reset");
    for (int k = 0; k < 4; k++) chk("reset_data", k, od[k], 32'd0);
    rstn = 1'b1; mon_en = 1'b1;

    // streaming at full rate
    step(1, 32'd1, 1, 0); step(1, 32'd2, 1, 0); step(1, 32'd3, 1, 0);
    repeat (4) step(0, 0, 1, 0);

    // A, idle, B, then stall; collapse keeps room for C
    step(1, 32'hA, 1, 0); step(0, 0, 1, 0); step(1, 32'hB, 1, 0); step(0, 0, 0, 0);
    set(1, 32'hC, 0, 0);
    #1;
    chk("stall_ready", 1, 32'(ir[1]), 32'd1);
    chk("stall_occ", 1, occ_of(1), 32'd2);
    chk("stall_head", 1, od[1], 32'hA);
    chk("lock_ready", 2, 32'(ir[2]), 32'd0);
    tick();
    set(0, 0, 0, 0);
    #1;
    chk("full_ready", 1, 32'(ir[1]), 32'd0);
    chk("full_occ", 1, occ_of(1), 32'd3);
    tick();
    repeat (5) step(0, 0, 1, 0);

    // fill while stalled, then flush with 0x55 offered
    step(1, 32'hD, 0, 0); step(1, 32'hE, 0, 0); step(1, 32'hF, 0, 0);
    chk("prefl_occ", 1, occ_of(1), 32'd3);
    step(1, 32'h55, 0, 1);
    chk_empty("flush");
    repeat (5) step(0, 0, 1, 0);

    // reset mid-stream
    step(1, 32'h10, 0, 0); step(1, 32'h20, 0, 0);
    chk("prerst_occ", 1, occ_of(1), 32'd2);
    rstn = 1'b0;
    step(1, 32'h30, 1, 0);
    rstn = 1'b1;
    chk_empty("rst");
    for (int k = 0; k < 4; k++) chk("rst_data", k, od[k], 32'd0);

    // lane packing
    step(1, 32'h44332211, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
    chk("lanes_valid", 1, 32'(ov[1]), 32'd1);
    chk("lanes_data", 1, od[1], 32'h44332211);
    chk("lane0", 1, 32'(od[1][7:0]), 32'h11);
    repeat (3) step(0, 0, 1, 0);

    for (int c = 0; c < 1000; c++) begin
      rstn = ($urandom_range(0, 199) != 0);
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
    end
    rstn = 1'b1;
    repeat (8) step(0, 0, 1, 0);
    chk("drained", 0, 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
